pos_sweep_ctrl: RTL and testbench
=================================

Name: pos_sweep_ctrl

Overview:
- Sequencer that exhaustively exercises a 3- or 4-input product-of-sums function block.
- Steps the input vector (x,y,w,z order, x = MSB) through every combination and holds each vector for a settle window.
- Samples the function output and compares it against the expected truth table derived from a maxterm mask.
- Reports the captured table, the mismatch count, the first failing index and pass/fail. Used as the on-chip self-check harness for the PoS function blocks.

Parameters:
- N_VARS, 4, number of function inputs; legal values 3 or 4.
- SETTLE, 1, cycles each vector is held before sampling; legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a sweep; honoured only in IDLE.
- abort  input  1  cancel a running sweep.
- maxterm_mask  input  16  bit i = 1 means f(i) = 0; bits at or above 2^N_VARS are ignored.
- vec_out  output  N_VARS  input vector driven to the function under test.
- f_in  input  1  output of the function under test.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- pass  output  1  1 when the last completed sweep had zero mismatches.
- err_count  output  5  number of mismatching vectors (0..16).
- err_valid  output  1  at least one mismatch seen.
- first_err_idx  output  4  lowest vector index that mismatched.
- captured_table  output  16  bit i = sampled f_in for vector i; unused bits are 0.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- On reset, every output goes to 0 immediately, state = IDLE, and the internal mask copy and index clear.
- State machine: IDLE, WAIT, SAMPLE, FIN.
- IDLE: busy = 0. When start = 1 at an edge:
  - Latch maxterm_mask; idx = 0.
  - Clear err_count, err_valid, first_err_idx, captured_table and pass.
  - Next state is WAIT if SETTLE > 0, otherwise SAMPLE.
  - busy = 1 from the following cycle.
- vec_out = idx whenever busy = 1 and is stable for the whole vector window. It holds its last value in IDLE, and is 0 after reset.
- WAIT: stays for exactly SETTLE cycles using a settle counter, then goes to SAMPLE.
- SAMPLE (one cycle):
  - expected = ~mask[idx].
  - captured_table[idx] <= f_in.
  - On f_in != expected: err_count increments. If err_valid = 0, set err_valid and set first_err_idx = idx.
  - If idx == 2^N_VARS - 1, go to FIN. Otherwise idx increments and the state returns to WAIT, or SAMPLE when SETTLE = 0.
- Per-vector cost is SETTLE + 1 cycles.
- FIN (one cycle): done = 1, busy = 0, pass = (err_count == 0, including the final sample's update); next state IDLE.
- Latency: start accepted at edge t0 gives done high during cycle t0 + 1 + 2^N_VARS*(SETTLE+1).
- Results hold until the next accepted start or reset.
- start while busy is ignored; it is neither queued nor a restart.
- start and abort both high in IDLE: start wins, abort has no effect.
- abort = 1 in WAIT or SAMPLE:
  - Next state IDLE, busy = 0 next cycle.
  - No done pulse, pass = 0.
  - captured_table, err_count and first_err_idx keep their partial values.
- abort and the final SAMPLE in the same cycle: abort wins; no done.
- N_VARS = 3: idx wraps at 7; mask bits 15:8 are ignored; captured_table bits 15:8 stay 0.
- err_count is saturation-free by construction (max 16 fits in 5 bits).

Test Plan:
- N_VARS=4, SETTLE=1, mask 0x2967, golden model f_in = ~mask[vec_out] -> done at t0+33, pass=1, err_count=0, err_valid=0, captured_table=0xD698.
- Same mask with f_in stuck at 1 -> err_count=8, err_valid=1, first_err_idx=0, pass=0, captured_table=0xFFFF.
- N_VARS=3, SETTLE=1, mask 0x00E2, golden model -> done at t0+17, captured_table=0x001D, pass=1. Also repeat with mask 0xFFE2 -> identical result (upper mask bits ignored).
- Assert start again mid-sweep -> no restart; vector sequence and done timing unchanged. Then assert abort while vec_out=5 -> busy=0 next cycle, no done pulse, pass=0.
- Assert reset asynchronously mid-sweep (between edges) -> all outputs 0 immediately. A fresh start after reset is released yields a normal pass at t0+33.
- N_VARS=4, SETTLE=0, golden model for mask 0x0000 -> vec_out increments every cycle, done at t0+17, captured_table=0xFFFF, pass=1.

Source files
------------

// File: rtl/pos_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : pos_sweep_ctrl_if
// Brief   : Control, stimulus and result bundle for the PoS sweep sequencer.
// Revision: 1.0
// ============================================================================
interface pos_sweep_ctrl_if #(
  parameter int N_VARS = 4
);
  logic              start;
  logic              abort;
  logic [15:0]       maxterm_mask;
  logic [N_VARS-1:0] vec_out;
  logic              f_in;
  logic              busy;
  logic              done;
  logic              pass;
  logic [4:0]        err_count;
  logic              err_valid;
  logic [3:0]        first_err_idx;
  logic [15:0]       captured_table;

  modport master (
    output start, abort, maxterm_mask, f_in,
    input  vec_out, busy, done, pass, err_count, err_valid, first_err_idx, captured_table
  );

  modport slave (
    input  start, abort, maxterm_mask, f_in,
    output vec_out, busy, done, pass, err_count, err_valid, first_err_idx, captured_table
  );
endinterface
`default_nettype wire

// File: rtl/pos_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pos_sweep_ctrl
// Brief   : Exhaustive input sweep and truth-table check of a PoS function.
// Revision: 1.0
// ============================================================================
module pos_sweep_ctrl #(
  parameter int N_VARS = 4,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  pos_sweep_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2,
    S_FIN    = 2'd3
  } state_t;

  // Each vector starts in WAIT unless there is no settle window at all.
  localparam state_t     C_FIRST       = (SETTLE > 0) ? S_WAIT : S_SAMPLE;
  localparam logic [3:0] C_SETTLE_LAST = 4'(SETTLE - 1);

  state_t            r_state;
  logic [15:0]       r_mask;
  logic [N_VARS-1:0] r_idx;
  logic [3:0]        r_settle;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic [4:0]        r_err_count;
  logic              r_err_valid;
  logic [3:0]        r_first;
  logic [15:0]       r_table;

  logic [3:0]        w_idx4;
  logic              w_mismatch;
  logic [4:0]        w_err_next;

  // Expected output is ~mask[idx], so equality with the mask bit is a miss.
  assign w_idx4     = 4'(r_idx);
  assign w_mismatch = (bus.f_in == r_mask[w_idx4]);
  assign w_err_next = r_err_count + 5'(w_mismatch);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_mask      <= '0;
      r_idx       <= '0;
      r_settle    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_count <= '0;
      r_err_valid <= 1'b0;
      r_first     <= '0;
      r_table     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mask      <= bus.maxterm_mask;
            r_idx       <= '0;
            r_settle    <= '0;
            r_busy      <= 1'b1;
            r_pass      <= 1'b0;
            r_err_count <= '0;
            r_err_valid <= 1'b0;
            r_first     <= '0;
            r_table     <= '0;
            r_state     <= C_FIRST;
          end
        end
        S_WAIT: begin
          if (bus.abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_settle == C_SETTLE_LAST) begin
            r_settle <= '0;
            r_state  <= S_SAMPLE;
          end else begin
            r_settle <= r_settle + 4'd1;
          end
        end
        S_SAMPLE: begin
          if (bus.abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_table[w_idx4] <= bus.f_in;
            if (w_mismatch) begin
              r_err_count <= w_err_next;
              if (!r_err_valid) begin
                r_err_valid <= 1'b1;
                r_first     <= w_idx4;
              end
            end
            if (&r_idx) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == 5'd0);
              r_state <= S_FIN;
            end else begin
              r_idx   <= r_idx + {{(N_VARS-1){1'b0}}, 1'b1};
              r_state <= C_FIRST;
            end
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.vec_out        = r_idx;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.pass           = r_pass;
  assign bus.err_count      = r_err_count;
  assign bus.err_valid      = r_err_valid;
  assign bus.first_err_idx  = r_first;
  assign bus.captured_table = r_table;

endmodule
`default_nettype wire

// File: tb/tb_pos_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pos_sweep_ctrl
// Brief   : Bench for pos_sweep_ctrl over (4,1), (3,1) and (4,0) configurations.
// Revision: 1.0
// ============================================================================
module tb_pos_sweep_ctrl;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pos_sweep_ctrl_if #(.N_VARS(4)) ifa ();
  pos_sweep_ctrl_if #(.N_VARS(3)) ifb ();
  pos_sweep_ctrl_if #(.N_VARS(4)) ifc ();

  pos_sweep_ctrl #(.N_VARS(4), .SETTLE(1)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  pos_sweep_ctrl #(.N_VARS(3), .SETTLE(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));
  pos_sweep_ctrl #(.N_VARS(4), .SETTLE(0)) dut_c (.clk(clk), .reset(reset), .bus(ifc.slave));

  // f_in modes: 0 golden (~mask), 1 stuck at 1, 2 stuck at 0, 3 arbitrary table
  logic        start_r [3];
  logic        abort_r [3];
  logic [15:0] mask_r  [3];
  int          fmode_r [3];
  logic [15:0] ftab_r  [3];

  function automatic logic fval(input int mode, input logic [15:0] mask,
                                input logic [15:0] tab, input logic [3:0] i);
    case (mode)
      0:       return ~mask[i];
      1:       return 1'b1;
      2:       return 1'b0;
      default: return tab[i];
    endcase
  endfunction

  assign ifa.start = start_r[0];
  assign ifb.start = start_r[1];
  assign ifc.start = start_r[2];
  assign ifa.abort = abort_r[0];
  assign ifb.abort = abort_r[1];
  assign ifc.abort = abort_r[2];
  assign ifa.maxterm_mask = mask_r[0];
  assign ifb.maxterm_mask = mask_r[1];
  assign ifc.maxterm_mask = mask_r[2];
  assign ifa.f_in = fval(fmode_r[0], mask_r[0], ftab_r[0], ifa.vec_out);
  assign ifb.f_in = fval(fmode_r[1], mask_r[1], ftab_r[1], {1'b0, ifb.vec_out});
  assign ifc.f_in = fval(fmode_r[2], mask_r[2], ftab_r[2], ifc.vec_out);

  logic [3:0]  vec_s   [3];
  logic        busy_s  [3];
  logic        done_s  [3];
  logic        pass_s  [3];
  logic [4:0]  err_s   [3];
  logic        valid_s [3];
  logic [3:0]  first_s [3];
  logic [15:0] tab_s   [3];

  assign vec_s[0] = ifa.vec_out;  assign vec_s[1] = {1'b0, ifb.vec_out};  assign vec_s[2] = ifc.vec_out;
  assign busy_s[0] = ifa.busy;    assign busy_s[1] = ifb.busy;            assign busy_s[2] = ifc.busy;
  assign done_s[0] = ifa.done;    assign done_s[1] = ifb.done;            assign done_s[2] = ifc.done;
  assign pass_s[0] = ifa.pass;    assign pass_s[1] = ifb.pass;            assign pass_s[2] = ifc.pass;
  assign err_s[0] = ifa.err_count; assign err_s[1] = ifb.err_count;       assign err_s[2] = ifc.err_count;
  assign valid_s[0] = ifa.err_valid; assign valid_s[1] = ifb.err_valid;   assign valid_s[2] = ifc.err_valid;
  assign first_s[0] = ifa.first_err_idx; assign first_s[1] = ifb.first_err_idx; assign first_s[2] = ifc.first_err_idx;
  assign tab_s[0] = ifa.captured_table; assign tab_s[1] = ifb.captured_table; assign tab_s[2] = ifc.captured_table;

  int n_tests;
  int n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected results straight from the truth-table definition.
  task automatic model(input int nv, input logic [15:0] mask, input int mode,
                       input logic [15:0] tab, output logic [15:0] e_tab,
                       output int e_err, output int e_first);
    e_tab = '0; e_err = 0; e_first = 0;
    for (int i = 0; i < (1 << nv); i++) begin
      logic f;
      f = fval(mode, mask, tab, 4'(i));
      e_tab[i] = f;
      if (f != !mask[i]) begin
        if (e_err == 0) e_first = i;
        e_err++;
      end
    end
  endtask

  task automatic check_all_zero(input int sel, input string tag);
    check({tag, " busy"},  32'(busy_s[sel]),  32'd0);
    check({tag, " done"},  32'(done_s[sel]),  32'd0);
    check({tag, " pass"},  32'(pass_s[sel]),  32'd0);
    check({tag, " err"},   32'(err_s[sel]),   32'd0);
    check({tag, " valid"}, 32'(valid_s[sel]), 32'd0);
    check({tag, " first"}, 32'(first_s[sel]), 32'd0);
    check({tag, " table"}, 32'(tab_s[sel]),   32'd0);
    check({tag, " vec"},   32'(vec_s[sel]),   32'd0);
  endtask

  task automatic run_sweep(input int sel, input int nv, input int st, input logic [15:0] mask,
                           input int mode, input logic [15:0] tab, input int restart_at,
                           input bit abort_too, input logic [15:0] e_tab, input int e_err,
                           input int e_first, input bit e_pass, input string tag);
    int total, e, vec_bad;
    bit seen;
    @(negedge clk);
    mask_r[sel] = mask; fmode_r[sel] = mode; ftab_r[sel] = tab;
    start_r[sel] = 1'b1; abort_r[sel] = abort_too;
    @(posedge clk);
    @(negedge clk);
    start_r[sel] = 1'b0; abort_r[sel] = 1'b0;
    total = (1 << nv) * (st + 1);
    e = 0; seen = 0; vec_bad = 0;
    while (e <= total + 5) begin
      if (done_s[sel]) begin
        seen = 1;
        break;
      end
      if (vec_s[sel] != 4'(e / (st + 1))) vec_bad++;
      if (!busy_s[sel]) vec_bad++;
      start_r[sel] = (e == restart_at);
      @(posedge clk);
      e++;
      @(negedge clk);
    end
    start_r[sel] = 1'b0;
    check({tag, " done latency"}, seen ? 32'(e) : 32'hFFFF_FFFF, 32'(total));
    check({tag, " vector seq"},   32'(vec_bad),        32'd0);
    check({tag, " busy at done"}, 32'(busy_s[sel]),    32'd0);
    check({tag, " pass"},         32'(pass_s[sel]),    32'(e_pass));
    check({tag, " err_count"},    32'(err_s[sel]),     32'(e_err));
    check({tag, " err_valid"},    32'(valid_s[sel]),   32'(e_err != 0));
    check({tag, " first_err"},    32'(first_s[sel]),   32'(e_first));
    check({tag, " table"},        32'(tab_s[sel]),     32'(e_tab));
    @(negedge clk);
    check({tag, " done pulse"},   32'(done_s[sel]),    32'd0);
  endtask

  typedef struct {
    int          sel;
    int          nv;
    int          st;
    logic [15:0] mask;
    int          mode;
    logic [15:0] tab;
    int          restart_at;
    bit          abort_too;
    logic [15:0] e_tab;
    int          e_err;
    int          e_first;
    bit          e_pass;
  } vec_t;

  vec_t vt [10];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 3; i++) begin
      start_r[i] = 0; abort_r[i] = 0; mask_r[i] = '0; fmode_r[i] = 0; ftab_r[i] = '0;
    end

    vt[0] = '{0, 4, 1, 16'h2967, 0, 16'h0000, -1, 0, 16'hD698, 0, 0, 1};
    vt[1] = '{0, 4, 1, 16'h2967, 1, 16'h0000, -1, 0, 16'hFFFF, 8, 0, 0};
    vt[2] = '{1, 3, 1, 16'h00E2, 0, 16'h0000, -1, 0, 16'h001D, 0, 0, 1};
    vt[3] = '{1, 3, 1, 16'hFFE2, 0, 16'h0000, -1, 0, 16'h001D, 0, 0, 1};
    vt[4] = '{1, 3, 1, 16'h00E2, 2, 16'h0000, -1, 0, 16'h0000, 4, 0, 0};
    vt[5] = '{0, 4, 1, 16'h2967, 0, 16'h0000,  9, 0, 16'hD698, 0, 0, 1};
    vt[6] = '{2, 4, 0, 16'h0000, 0, 16'h0000, -1, 0, 16'hFFFF, 0, 0, 1};
    vt[7] = '{2, 4, 0, 16'hFFFF, 0, 16'h0000, -1, 0, 16'h0000, 0, 0, 1};
    vt[8] = '{0, 4, 1, 16'h0001, 0, 16'h0000, -1, 1, 16'hFFFE, 0, 0, 1};
    vt[9] = '{0, 4, 1, 16'h0F0F, 3, 16'h1234, -1, 0, 16'h1234, 7, 2, 0};

    reset = 1'b1;
    #1;
    check_all_zero(0, "reset A");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_all_zero(1, "reset B");

    foreach (vt[k]) begin
      run_sweep(vt[k].sel, vt[k].nv, vt[k].st, vt[k].mask, vt[k].mode, vt[k].tab,
                vt[k].restart_at, vt[k].abort_too, vt[k].e_tab, vt[k].e_err,
                vt[k].e_first, vt[k].e_pass, $sformatf("vec%0d", k));
    end

    // Abort while vector 5 is on the bus: partial results stay, no done.
    begin
      int guard, dones;
      @(negedge clk);
      mask_r[0] = 16'h2967; fmode_r[0] = 1; start_r[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_r[0] = 1'b0;
      guard = 0;
      while (vec_s[0] != 4'd5 && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      check("abort reach vec5", 32'(guard < 50), 32'd1);
      abort_r[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      abort_r[0] = 1'b0;
      check("abort busy", 32'(busy_s[0]), 32'd0);
      dones = 0;
      for (int i = 0; i < 40; i++) begin
        if (done_s[0]) dones++;
        @(negedge clk);
      end
      check("abort no done", 32'(dones),       32'd0);
      check("abort pass",    32'(pass_s[0]),   32'd0);
      check("abort err",     32'(err_s[0]),    32'd3);
      check("abort valid",   32'(valid_s[0]),  32'd1);
      check("abort first",   32'(first_s[0]),  32'd0);
      check("abort table",   32'(tab_s[0]),    32'h001F);
    end

    // Asynchronous reset between edges in the middle of a sweep.
    @(negedge clk);
    mask_r[0] = 16'h2967; fmode_r[0] = 0; start_r[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_r[0] = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero(0, "async reset");
    @(negedge clk);
    reset = 1'b0;
    run_sweep(0, 4, 1, 16'h2967, 0, 16'h0000, -1, 0, 16'hD698, 0, 0, 1, "post reset");

    // Randomized sweeps on every configuration against the truth-table model.
    for (int r = 0; r < 12; r++) begin
      int sel, nv, st, mode, e_err, e_first;
      logic [15:0] mask, tab, e_tab;
      sel  = r % 3;
      nv   = (sel == 1) ? 3 : 4;
      st   = (sel == 2) ? 0 : 1;
      mask = 16'($urandom);
      tab  = 16'($urandom);
      mode = int'($urandom_range(0, 3));
      model(nv, mask, mode, tab, e_tab, e_err, e_first);
      run_sweep(sel, nv, st, mask, mode, tab, -1, 0, e_tab, e_err, e_first, e_err == 0,
                $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
